// File: rtl/timer_scheduler_pkg.sv
// Shared register map and bit positions for the timer scheduler.
// Every file that decodes or builds register fields imports this package.
package timer_scheduler_pkg;

    typedef enum logic [1:0] {
        REG_PERIOD   = 2'd0,
        REG_CONTROL  = 2'd1,
        REG_STATUS   = 2'd2,
        REG_DEADLINE = 2'd3
    } reg_sel_e;

    localparam int CTRL_ENABLE   = 0;
    localparam int CTRL_PERIODIC = 1;

    localparam int STAT_IRQ      = 0;
    localparam int STAT_OVERRUN  = 1;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: period/deadline state, match detection, periodic reload
// and sticky irq/overrun flags with write-1-to-clear.
module timer_channel
    import timer_scheduler_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_count,
    input  logic             i_wr_period,
    input  logic             i_wr_control,
    input  logic             i_wr_status,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_period,
    output logic [WIDTH-1:0] o_deadline,
    output logic             o_enable,
    output logic             o_periodic,
    output logic             o_irq,
    output logic             o_overrun
);

    localparam logic [WIDTH-1:0] P_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_deadline;
    logic             r_enable;
    logic             r_periodic;
    logic             r_irq;
    logic             r_overrun;
    logic             w_match;

    assign w_match = r_enable && (i_count == r_deadline);

    // Later assignments override earlier ones: a disable beats a match's
    // reload, and a match's set beats a status clear in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_period   <= P_ONE;
            r_deadline <= '0;
            r_enable   <= 1'b0;
            r_periodic <= 1'b0;
            r_irq      <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (i_wr_period) begin
                r_period <= (i_data == '0) ? P_ONE : i_data;
            end

            if (w_match) begin
                if (r_periodic) begin
                    r_deadline <= r_deadline + r_period;
                end else begin
                    r_enable <= 1'b0;
                end
            end

            if (i_wr_control) begin
                r_periodic <= i_data[CTRL_PERIODIC];
                if (!r_enable) begin
                    r_enable <= i_data[CTRL_ENABLE];
                    if (i_data[CTRL_ENABLE]) begin
                        r_deadline <= i_count + r_period;
                    end
                end else if (!i_data[CTRL_ENABLE]) begin
                    r_enable <= 1'b0;
                end
            end

            if (i_wr_status && i_data[STAT_IRQ]) begin
                r_irq <= 1'b0;
            end
            if (i_wr_status && i_data[STAT_OVERRUN]) begin
                r_overrun <= 1'b0;
            end

            if (w_match) begin
                r_irq <= 1'b1;
                if (r_irq) begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    assign o_period   = r_period;
    assign o_deadline = r_deadline;
    assign o_enable   = r_enable;
    assign o_periodic = r_periodic;
    assign o_irq      = r_irq;
    assign o_overrun  = r_overrun;

endmodule

// File: rtl/timer_scheduler.sv
// Multi-channel deadline timer: address decode, per-channel timers,
// registered read-back mux and a registered any-irq summary.
module timer_scheduler
    import timer_scheduler_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [WIDTH-1:0]              count,
    input  logic                          we,
    input  logic [$clog2(CHANNELS)+1:0]   addr,
    input  logic [WIDTH-1:0]              data_in,
    output logic [WIDTH-1:0]              data_out,
    output logic [CHANNELS-1:0]           irq,
    output logic                          irq_any
);

    localparam int ADDR_W = $clog2(CHANNELS) + 2;
    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CH_W-1:0]     w_ch;
    reg_sel_e            w_reg;
    logic [CHANNELS-1:0] w_wr_period;
    logic [CHANNELS-1:0] w_wr_control;
    logic [CHANNELS-1:0] w_wr_status;
    logic [WIDTH-1:0]    w_period   [CHANNELS];
    logic [WIDTH-1:0]    w_deadline [CHANNELS];
    logic [CHANNELS-1:0] w_enable;
    logic [CHANNELS-1:0] w_periodic;
    logic [CHANNELS-1:0] w_irq;
    logic [CHANNELS-1:0] w_overrun;
    logic [WIDTH-1:0]    w_rd_data;
    logic [WIDTH-1:0]    r_data_out;
    logic                r_irq_any;

    assign w_reg = reg_sel_e'(addr[1:0]);

    generate
        if (CHANNELS == 1) begin : g_ch_single
            assign w_ch = '0;
        end else begin : g_ch_multi
            assign w_ch = addr[ADDR_W-1:2];
        end
    endgenerate

    always_comb begin
        w_wr_period  = '0;
        w_wr_control = '0;
        w_wr_status  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (we && (w_ch == CH_W'(i))) begin
                w_wr_period[i]  = (w_reg == REG_PERIOD);
                w_wr_control[i] = (w_reg == REG_CONTROL);
                w_wr_status[i]  = (w_reg == REG_STATUS);
            end
        end
    end

    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
            timer_channel #(
                .WIDTH (WIDTH)
            ) u_channel (
                .clk          (clk),
                .reset_n      (reset_n),
                .i_count      (count),
                .i_wr_period  (w_wr_period[g]),
                .i_wr_control (w_wr_control[g]),
                .i_wr_status  (w_wr_status[g]),
                .i_data       (data_in),
                .o_period     (w_period[g]),
                .o_deadline   (w_deadline[g]),
                .o_enable     (w_enable[g]),
                .o_periodic   (w_periodic[g]),
                .o_irq        (w_irq[g]),
                .o_overrun    (w_overrun[g])
            );
        end
    endgenerate

    always_comb begin
        w_rd_data = '0;
        case (w_reg)
            REG_PERIOD: begin
                w_rd_data = w_period[w_ch];
            end
            REG_CONTROL: begin
                w_rd_data[CTRL_ENABLE]   = w_enable[w_ch];
                w_rd_data[CTRL_PERIODIC] = w_periodic[w_ch];
            end
            REG_STATUS: begin
                w_rd_data[STAT_IRQ]     = w_irq[w_ch];
                w_rd_data[STAT_OVERRUN] = w_overrun[w_ch];
            end
            REG_DEADLINE: begin
                w_rd_data = w_deadline[w_ch];
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_out <= '0;
            r_irq_any  <= 1'b0;
        end else begin
            r_data_out <= w_rd_data;
            r_irq_any  <= |w_irq;
        end
    end

    assign data_out = r_data_out;
    assign irq      = w_irq;
    assign irq_any  = r_irq_any;

endmodule

// File: tb/tb_timer_scheduler.sv
// Scoreboard bench for timer_scheduler (8-bit counter, 4 channels): register
// reads are queued with their expected value and compared when data_out lands.
module tb_timer_scheduler;
    import timer_scheduler_pkg::*;

    localparam int W  = 8;
    localparam int CH = 4;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic          we      = 1'b0;
    logic [W-1:0]  count   = '0;
    logic [3:0]    addr    = '0;
    logic [W-1:0]  data_in = '0;
    logic [W-1:0]  data_out;
    logic [CH-1:0] irq;
    logic          irq_any;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string        tag;
        logic [W-1:0] exp;
    } exp_t;
    exp_t sb[$];

    timer_scheduler #(
        .WIDTH    (W),
        .CHANNELS (CH)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .count    (count),
        .we       (we),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .irq      (irq),
        .irq_any  (irq_any)
    );

    always #5 clk = ~clk;

    // Free-running count, advanced just after each rising edge.
    always @(posedge clk) begin
        #1;
        count = count + 8'd1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    task automatic wait_count(input logic [W-1:0] v);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (count != v && n < 600);
        if (count != v) chk("timeout", 32'(count), 32'(v));
    endtask

    task automatic wr(input int ch, input reg_sel_e r, input logic [W-1:0] d);
        we      = 1'b1;
        addr    = {2'(ch), r};
        data_in = d;
        @(negedge clk);
        we      = 1'b0;
    endtask

    task automatic rd(input string tag, input int ch, input reg_sel_e r, input logic [W-1:0] exp);
        exp_t e;
        addr  = {2'(ch), r};
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        chk(e.tag, 32'(data_out), 32'(e.exp));
    endtask

    initial begin
        logic seen;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_irq_any", 32'(irq_any), 0);
        chk("rst_data_out", 32'(data_out), 0);
        reset_n = 1'b1;
        rd("rst_period0", 0, REG_PERIOD, 1);
        rd("rst_control0", 0, REG_CONTROL, 0);
        rd("rst_status0", 0, REG_STATUS, 0);
        rd("rst_deadline0", 0, REG_DEADLINE, 0);

        // One-shot on channel 0: enable at 100, period 10
        wait_count(99);
        wr(0, REG_PERIOD, 10);
        wr(0, REG_CONTROL, 8'b01);
        rd("os_deadline0", 0, REG_DEADLINE, 110);
        wait_count(110);
        chk("os_irq_before", 32'(irq[0]), 0);
        @(negedge clk);
        chk("os_irq_after", 32'(irq[0]), 1);
        chk("os_irq_any_lag", 32'(irq_any), 0);
        @(negedge clk);
        chk("os_irq_any", 32'(irq_any), 1);
        rd("os_enable_cleared", 0, REG_CONTROL, 0);
        wr(0, REG_STATUS, 8'b01);
        rd("os_status_cleared", 0, REG_STATUS, 0);
        seen = 1'b0;
        repeat (270) begin
            @(negedge clk);
            seen |= irq[0];
        end
        chk("os_no_rearm", 32'(seen), 0);

        // Status clear in the exact match cycle: set wins
        wait_count(119);
        wr(0, REG_PERIOD, 10);
        wr(0, REG_CONTROL, 8'b01);
        wait_count(130);
        wr(0, REG_STATUS, 8'b01);
        rd("setwins_status0", 0, REG_STATUS, 8'b01);
        wr(0, REG_STATUS, 8'b01);
        rd("setwins_cleared", 0, REG_STATUS, 0);

        // Re-write of CONTROL while enabled does not re-arm; disable at match
        wait_count(139);
        wr(0, REG_PERIOD, 10);
        wr(0, REG_CONTROL, 8'b11);
        wait_count(145);
        wr(0, REG_CONTROL, 8'b11);
        rd("norearm_deadline0", 0, REG_DEADLINE, 150);
        rd("norearm_control0", 0, REG_CONTROL, 8'b11);
        wait_count(150);
        wr(0, REG_CONTROL, 8'b00);
        rd("dis_control0", 0, REG_CONTROL, 0);
        rd("dis_status0", 0, REG_STATUS, 8'b01);
        wr(0, REG_STATUS, 8'b11);

        // Periodic channel 1: period 5 from count 0, overrun without clears
        wait_count(255);
        wr(1, REG_PERIOD, 5);
        wr(1, REG_CONTROL, 8'b11);
        wait_count(5);
        chk("per_irq1_before", 32'(irq[1]), 0);
        @(negedge clk);
        chk("per_irq1_after", 32'(irq[1]), 1);
        rd("per_status1_first", 1, REG_STATUS, 8'b01);
        chk("per_irq_any", 32'(irq_any), 1);
        wait_count(11);
        rd("per_status1_overrun", 1, REG_STATUS, 8'b11);
        rd("per_deadline1", 1, REG_DEADLINE, 15);
        wait_count(20);
        wr(1, REG_STATUS, 8'b11);
        rd("per_setwins_overrun", 1, REG_STATUS, 8'b11);
        wr(1, REG_CONTROL, 8'b00);
        wr(1, REG_STATUS, 8'b11);
        rd("per_status1_clear", 1, REG_STATUS, 0);
        wait_count(26);
        chk("per_irq1_stopped", 32'(irq[1]), 0);

        // Wrap on channel 2, then a period change that waits for the next reload
        wait_count(249);
        wr(2, REG_PERIOD, 20);
        wr(2, REG_CONTROL, 8'b11);
        rd("wrap_deadline2", 2, REG_DEADLINE, 14);
        wait_count(14);
        chk("wrap_irq2_before", 32'(irq[2]), 0);
        @(negedge clk);
        chk("wrap_irq2_after", 32'(irq[2]), 1);
        rd("wrap_next_deadline2", 2, REG_DEADLINE, 34);
        wait_count(20);
        wr(2, REG_PERIOD, 30);
        rd("pchg_deadline_kept", 2, REG_DEADLINE, 34);
        wait_count(34);
        @(negedge clk);
        rd("pchg_deadline_new", 2, REG_DEADLINE, 64);
        rd("pchg_status2", 2, REG_STATUS, 8'b11);
        wr(2, REG_CONTROL, 8'b00);
        wr(2, REG_STATUS, 8'b11);

        // Zero period stored as one on channel 3
        wait_count(6);
        wr(3, REG_PERIOD, 0);
        wr(3, REG_CONTROL, 8'b01);
        chk("p0_irq3_before", 32'(irq[3]), 0);
        rd("p0_period3", 3, REG_PERIOD, 1);
        chk("p0_irq3_after", 32'(irq[3]), 1);

        // Reset mid-operation cancels channel 1 deadline at 50
        wait_count(29);
        wr(1, REG_PERIOD, 20);
        wr(1, REG_CONTROL, 8'b01);
        wait_count(39);
        rd("mid_period1", 1, REG_PERIOD, 20);
        chk("mid_irq_pre", 32'(irq), 32'h8);
        chk("mid_irq_any_pre", 32'(irq_any), 1);
        reset_n = 1'b0;
        #1;
        chk("mid_irq_rst", 32'(irq), 0);
        chk("mid_irq_any_rst", 32'(irq_any), 0);
        chk("mid_data_out_rst", 32'(data_out), 0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_count(50);
        @(negedge clk);
        chk("mid_no_irq", 32'(irq), 0);
        @(negedge clk);
        chk("mid_no_irq_any", 32'(irq_any), 0);
        rd("mid_deadline1", 1, REG_DEADLINE, 0);
        rd("mid_control1", 1, REG_CONTROL, 0);
        rd("mid_period1_rst", 1, REG_PERIOD, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
